// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU code-memory loader: default widths and
// the loader state encoding.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/load_addr_counter.sv
// Code-memory write address counter. Clear wins over increment; at_max
// flags the last address so the loader can stop without wrapping.
module load_addr_counter #(
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              incr,
  output logic [ADDR_W-1:0] count,
  output logic              at_max
);

  // Address register: cleared at session start, stepped after each write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = &count;

endmodule

// File: rtl/program_loader.sv
// Loads a program word-by-word into code memory while holding the CPU in
// reset, pads unused addresses with FILL_WORD, then releases the CPU.
// The system CPU reset is expected to be (reset | cpu_hold).
//
//   state | meaning
//   IDLE  | after reset; CPU held, waiting for start
//   RECV  | waiting for the next program word (word_ready=1)
//   WRITE | one-cycle write of the captured word at the counter address
//   FILL  | writing FILL_WORD to every remaining address through max
//   RUN   | program loaded; CPU released, done=1
//   ERR   | too many words offered; CPU held, error=1
module program_loader
  import cpu_pkg::*;
#(
  parameter int               DATA_W    = CPU_DATA_W,
  parameter int               ADDR_W    = CPU_ADDR_W,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_in,
  input  logic              word_last,
  output logic              word_ready,
  output logic              cmem_we,
  output logic [ADDR_W-1:0] cmem_addr,
  output logic [DATA_W-1:0] cmem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  loader_state_t state, state_nxt;

  logic              cnt_clear;
  logic              cnt_incr;
  logic              capture;
  logic [ADDR_W-1:0] addr_cnt;
  logic              addr_at_max;
  logic [DATA_W-1:0] word_q;
  logic              last_q;

  load_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .incr   (cnt_incr),
    .count  (addr_cnt),
    .at_max (addr_at_max)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Holding register for the accepted word and its last flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      last_q <= 1'b0;
    end else if (capture) begin
      word_q <= word_in;
      last_q <= word_last;
    end
  end

  // Next-state and counter control; start is only honoured in IDLE/RUN/ERR.
  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_nxt = ST_RECV;
          cnt_clear = 1'b1;
        end
      end
      ST_RECV: begin
        if (word_valid) begin
          state_nxt = ST_WRITE;
          capture   = 1'b1;
        end
      end
      ST_WRITE: begin
        // At the top address there is nowhere left to go: a last word
        // finishes the load, anything else is an overflow.
        if (addr_at_max) begin
          state_nxt = last_q ? ST_RUN : ST_ERR;
        end else begin
          state_nxt = last_q ? ST_FILL : ST_RECV;
          cnt_incr  = 1'b1;
        end
      end
      ST_FILL: begin
        if (addr_at_max) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_incr = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Moore outputs; the write port is forced to zero when not strobed.
  always_comb begin
    word_ready = 1'b0;
    cmem_we    = 1'b0;
    cmem_addr  = '0;
    cmem_wdata = '0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      ST_RECV: begin
        word_ready = 1'b1;
      end
      ST_WRITE: begin
        cmem_we    = 1'b1;
        cmem_addr  = addr_cnt;
        cmem_wdata = word_q;
      end
      ST_FILL: begin
        cmem_we    = 1'b1;
        cmem_addr  = addr_cnt;
        cmem_wdata = FILL_WORD;
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERR: begin
        error = 1'b1;
      end
      default: begin
        cpu_hold = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader. Expected code-memory writes are
// derived from the load rules (word i goes to address i, the remainder is
// padded with FILL_WORD) and consumed by a per-cycle compare process.
module tb_program_loader;

  localparam int          DW    = 16;
  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam logic [DW-1:0] FILL = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          word_valid;
  logic [DW-1:0] word_in;
  logic          word_last;
  logic          word_ready;
  logic          cmem_we;
  logic [AW-1:0] cmem_addr;
  logic [DW-1:0] cmem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_a[$];
  logic [DW-1:0] exp_d[$];
  logic [DW-1:0] src[$];

  program_loader #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .FILL_WORD (FILL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_valid (word_valid),
    .word_in    (word_in),
    .word_last  (word_last),
    .word_ready (word_ready),
    .cmem_we    (cmem_we),
    .cmem_addr  (cmem_addr),
    .cmem_wdata (cmem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle checker: scoreboard of writes plus output invariants.
  always @(negedge clk) begin
    if (reset) begin
      exp_a.delete();
      exp_d.delete();
      chk("rst_we", cmem_we, 0);
      chk("rst_hold", cpu_hold, 1);
      chk("rst_ready", word_ready, 0);
      chk("rst_done_err", {done, error}, 0);
    end else begin
      if (cmem_we) begin
        if (exp_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h, required no write", cmem_addr, cmem_wdata);
        end else begin
          chk("write_addr", cmem_addr, exp_a.pop_front());
          chk("write_data", cmem_wdata, exp_d.pop_front());
        end
        chk("ready_in_write", word_ready, 0);
      end else begin
        chk("quiet_addr", cmem_addr, 0);
        chk("quiet_data", cmem_wdata, 0);
      end
      chk("hold_vs_done", cpu_hold, !done);
      chk("done_err_excl", done & error, 0);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offer one word; returns at the negedge following acceptance.
  task automatic send_word(input logic [DW-1:0] d, input bit l);
    int b = 0;
    word_valid = 1'b1;
    word_in    = d;
    word_last  = l;
    while (!word_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("handshake_timeout", (b < 50), 1);
    @(negedge clk);
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  // One load session of n words taken from src. start_mid pulses start
  // while waiting for that word; stall_at withholds valid for 10 cycles.
  task automatic load(input int n, input bit with_last, input bit randgap,
                      input int start_mid, input int stall_at);
    int cyc;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      if (randgap) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i == start_mid) pulse_start();
      if (i == stall_at) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("stall_ready", word_ready, 1);
          chk("stall_we", cmem_we, 0);
        end
      end
      exp_a.push_back(i);
      exp_d.push_back(src[i]);
      send_word(src[i], with_last && (i == n - 1));
    end
    if (with_last) begin
      for (int a = n; a < DEPTH; a++) begin
        exp_a.push_back(a);
        exp_d.push_back(FILL);
      end
      cyc = 1;
      while (!done && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("run_latency", cyc, 66 - n);
      chk("run_done", done, 1);
      chk("run_hold", cpu_hold, 0);
      chk("run_error", error, 0);
      chk("pending_writes", exp_a.size(), 0);
    end else begin
      @(negedge clk);
      chk("ovf_error", error, 1);
      chk("ovf_ready", word_ready, 0);
      chk("ovf_hold", cpu_hold, 1);
      chk("ovf_done", done, 0);
      chk("ovf_pending", exp_a.size(), 0);
      word_valid = 1'b1;
      word_in    = 16'hBEEF;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("ovf_ready_hold", word_ready, 0);
        chk("ovf_error_hold", error, 1);
      end
      word_valid = 1'b0;
    end
  endtask

  task automatic fill_src_random(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(DW'($urandom));
  endtask

  initial begin
    int n;
    int b;
    reset      = 1'b1;
    start      = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    word_last  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", word_ready, 0);
    chk("idle_hold", cpu_hold, 1);
    chk("idle_done", done, 0);
    chk("idle_error", error, 0);

    // Three-word program with hand-picked data.
    src.delete();
    src.push_back(16'h1101);
    src.push_back(16'h2202);
    src.push_back(16'h3303);
    load(3, 1, 0, -1, -1);

    // start in RUN re-enters RECV on the next cycle.
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_hold", cpu_hold, 1);
    chk("restart_ready", word_ready, 1);

    // Full-depth program: no fill, RUN right after the addr-63 write.
    fill_src_random(64);
    load(64, 1, 0, -1, -1);

    // Single word: longest fill.
    fill_src_random(1);
    load(1, 1, 0, -1, -1);

    // Mid-session start ignored, and a 10-cycle valid stall.
    fill_src_random(5);
    load(5, 1, 1, 2, 3);

    // Overflow: 64 words without last, 65th offered but never taken.
    fill_src_random(64);
    load(64, 0, 1, -1, -1);
    pulse_start();
    chk("err_restart_error", error, 0);
    chk("err_restart_ready", word_ready, 1);
    fill_src_random(2);
    load(2, 1, 0, -1, -1);

    // Reset in the middle of the fill at address 20.
    fill_src_random(3);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back(i);
      exp_d.push_back(src[i]);
      send_word(src[i], i == 2);
    end
    for (int a = 3; a < DEPTH; a++) begin
      exp_a.push_back(a);
      exp_d.push_back(FILL);
    end
    b = 0;
    while (!(cmem_we && cmem_addr == 19) && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("reach_addr19", (b < 100), 1);
    @(posedge clk);
    #1;
    chk("pre_rst_addr20", cmem_addr, 20);
    reset = 1'b1;
    #1;
    exp_a.delete();
    exp_d.delete();
    chk("async_rst_we", cmem_we, 0);
    chk("async_rst_hold", cpu_hold, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", word_ready, 0);
    fill_src_random(2);
    load(2, 1, 0, -1, -1);

    // Random sessions.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 64);
      fill_src_random(n);
      load(n, 1, 1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
